seq_stage_controller: RTL and testbench

//  Multi-cycle sequencer for the Y86-64 SEQ datapath. Owns the PC register and

---
 rtl/seq_stage_controller_if.sv | 47 ++++
 rtl/seq_stage_controller.sv | 134 +++++++++++++
 tb/tb_seq_stage_controller.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_controller_if.sv
// Bundle between the SEQ stage sequencer (master) and the SEQ datapath (slave).
// Optional SEQ_PERF_COUNTERS_EN adds cycle_count / instr_count.
interface seq_stage_controller_if;
  logic        start;
  logic [3:0]  icode;
  logic        instruct_error;
  logic        imem_error;
  logic        dmem_error;
  logic        mem_ready;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic [63:0] pc;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        writeback_en;
  logic [2:0]  stat;
  logic        halted;
  logic        retire;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [63:0] cycle_count;
  logic [63:0] instr_count;
`endif

  modport master (
    input  start, icode, instruct_error, imem_error, dmem_error, mem_ready,
           cnd, valC, valP, valM,
    output pc, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           stat, halted, retire
`ifdef SEQ_PERF_COUNTERS_EN
    , output cycle_count, instr_count
`endif
  );

  modport slave (
    output start, icode, instruct_error, imem_error, dmem_error, mem_ready,
           cnd, valC, valP, valM,
    input  pc, fetch_en, decode_en, execute_en, memory_en, writeback_en,
           stat, halted, retire
`ifdef SEQ_PERF_COUNTERS_EN
    , input cycle_count, instr_count
`endif
  );
endinterface

// File: rtl/seq_stage_controller.sv
// Y86-64 SEQ multi-cycle sequencer: owns PC, steps stages, tracks stat.
// Define SEQ_PERF_COUNTERS_EN to add saturating cycle/instruction counters.
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                    clk,
  input logic                    reset,
  seq_stage_controller_if.master bus
);
  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        icode_q;
  logic [63:0]       valm_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        stat_nxt;
  logic [63:0]       pc_nxt;
  logic              mem_icode;

  always_comb begin
    mem_icode = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  end

  always_comb begin
    state_nxt = state;
    stat_nxt  = bus.stat;
    pc_nxt    = bus.pc;
    unique case (state)
      S_IDLE:      if (bus.start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_error) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_HALT;
        end else if (bus.instruct_error) begin
          stat_nxt  = STAT_INS;
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_MEMORY;
      // dmem_error outranks mem_ready; timeout only once the full budget is spent
      S_MEMORY: begin
        if (bus.dmem_error) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_HALT;
        end else if (!mem_icode || bus.mem_ready) begin
          state_nxt = S_WRITEBACK;
        end else if (wait_cnt == WAIT_LIMIT) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_HALT;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPDATE;
      S_PCUPDATE: begin
        if (icode_q == 4'h8 || (icode_q == 4'h7 && bus.cnd)) pc_nxt = bus.valC;
        else if (icode_q == 4'h9)                             pc_nxt = valm_q;
        else                                                  pc_nxt = bus.valP;
        if (icode_q == 4'h0) begin
          stat_nxt  = STAT_HLT;
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      bus.pc           <= RESET_PC;
      bus.stat         <= STAT_AOK;
      bus.fetch_en     <= 1'b0;
      bus.decode_en    <= 1'b0;
      bus.execute_en   <= 1'b0;
      bus.memory_en    <= 1'b0;
      bus.writeback_en <= 1'b0;
      bus.halted       <= 1'b0;
      bus.retire       <= 1'b0;
      icode_q          <= '0;
      valm_q           <= '0;
      wait_cnt         <= '0;
`ifdef SEQ_PERF_COUNTERS_EN
      bus.cycle_count  <= '0;
      bus.instr_count  <= '0;
`endif
    end else begin
      state            <= state_nxt;
      bus.pc           <= pc_nxt;
      bus.stat         <= stat_nxt;
      // outputs registered from the next state so they line up with state
      bus.fetch_en     <= (state_nxt == S_FETCH);
      bus.decode_en    <= (state_nxt == S_DECODE);
      bus.execute_en   <= (state_nxt == S_EXECUTE);
      bus.memory_en    <= (state_nxt == S_MEMORY);
      bus.writeback_en <= (state_nxt == S_WRITEBACK);
      bus.halted       <= (state_nxt == S_HALT);
      bus.retire       <= (state_nxt == S_PCUPDATE);
      if (state == S_FETCH) icode_q <= bus.icode;
      if (state == S_MEMORY && bus.mem_ready) valm_q <= bus.valM;
      if (state != S_MEMORY)  wait_cnt <= '0;
      else if (!bus.mem_ready) wait_cnt <= wait_cnt + 1'b1;
`ifdef SEQ_PERF_COUNTERS_EN
      if (state != S_IDLE && state != S_HALT && bus.cycle_count != '1)
        bus.cycle_count <= bus.cycle_count + 64'd1;
      if (bus.retire && bus.instr_count != '1)
        bus.instr_count <= bus.instr_count + 64'd1;
`endif
    end
  end
endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: driver predicts each instruction's
// outcome from the architectural rules; a negedge monitor pops and compares.
module tb_seq_stage_controller;
  localparam logic [63:0] RESET_PC     = 64'h0;
  localparam int          MEM_WAIT_MAX = 15;
  localparam int          NEVER        = 99;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_stage_controller_if bus ();

  seq_stage_controller #(
    .RESET_PC     (RESET_PC),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] valm;
    logic        imem_err;
    logic        ins_err;
    int          ready_at;
    int          dmem_at;
  } instr_t;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        retired;
    int          cycles;
    int          mcyc;
    int          wcyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Architectural outcome of one instruction, walked cycle by cycle through memory waits.
  function automatic exp_t predict(input instr_t in, input logic [63:0] cur_pc);
    exp_t e;
    bit   fault;
    bit   done;
    e.pc = cur_pc; e.retired = 1'b0; e.mcyc = 0; e.wcyc = 0; e.stat = 3'd1; e.cycles = 0;
    if (in.imem_err) begin e.stat = 3'd3; e.cycles = 1; return e; end
    if (in.ins_err)  begin e.stat = 3'd4; e.cycles = 1; return e; end
    fault = 1'b0;
    done  = 1'b0;
    if (in.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
      for (int k = 0; !done; k++) begin
        if (k == in.dmem_at)           begin fault = 1'b1; done = 1'b1; end
        else if (k == in.ready_at)     done = 1'b1;
        else if (k == MEM_WAIT_MAX)    begin fault = 1'b1; done = 1'b1; end
        e.mcyc = k + 1;
      end
    end else begin
      e.mcyc = 1;
    end
    if (fault) begin e.stat = 3'd3; e.cycles = 3 + e.mcyc; return e; end
    e.wcyc = 1; e.retired = 1'b1; e.cycles = 5 + e.mcyc;
    if (in.icode == 4'h8 || (in.icode == 4'h7 && in.cnd)) e.pc = in.valc;
    else if (in.icode == 4'h9)                              e.pc = in.valm;
    else                                                    e.pc = in.valp;
    e.stat = (in.icode == 4'h0) ? 3'd2 : 3'd1;
    return e;
  endfunction

  function automatic instr_t mk(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                                input logic [63:0] vp, input logic [63:0] vm,
                                input int rdy, input int dm);
    instr_t in;
    in.icode = ic; in.cnd = c; in.valc = vc; in.valp = vp; in.valm = vm;
    in.imem_err = 1'b0; in.ins_err = 1'b0; in.ready_at = rdy; in.dmem_at = dm;
    return in;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.imem_error = 1'b0; bus.instruct_error = 1'b0;
    bus.dmem_error = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_pc = RESET_PC;
    sbq.delete();
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_instr(input instr_t in);
    exp_t e;
    int   n;
    int   k;
    n = 0;
    while (!bus.fetch_en && n < 40) begin @(posedge clk); #1; n++; end
    if (!bus.fetch_en) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_wait: actual fetch_en=0 required 1 within 40 cycles");
      return;
    end
    bus.icode = in.icode; bus.cnd = in.cnd; bus.valC = in.valc; bus.valP = in.valp;
    bus.valM = in.valm; bus.imem_error = in.imem_err; bus.instruct_error = in.ins_err;
    e = predict(in, model_pc);
    model_pc = e.pc;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.imem_error = 1'b0; bus.instruct_error = 1'b0;
    n = 0; k = 0;
    while (!bus.fetch_en && !bus.halted && n < 64) begin
      if (bus.memory_en) begin
        bus.mem_ready  = (k == in.ready_at);
        bus.dmem_error = (k == in.dmem_at);
        k++;
      end else begin
        bus.mem_ready  = 1'b0;
        bus.dmem_error = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
    if (n >= 64) begin
      n_cmp++; n_bad++;
      $display("FAIL instr_done: actual no fetch/halt required one within 64 cycles");
    end
    @(negedge clk); #1;
  endtask

  // Monitor: one outcome per instruction (cycle after retire, or halted rising).
  initial begin
    bit   act;
    int   cyc, mc, wc;
    logic pr, ph;
    exp_t e;
    act = 1'b0; cyc = 0; mc = 0; wc = 0; pr = 1'b0; ph = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin act = 1'b0; pr = 1'b0; ph = 1'b0; continue; end
      if (pr || (bus.halted && !ph)) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_outcome: actual outcome at pc=%0h required none", bus.pc);
        end else begin
          e = sbq.pop_front();
          check("pc", bus.pc, e.pc);
          check("stat", 64'(bus.stat), 64'(e.stat));
          check("retired", 64'(pr), 64'(e.retired));
          check("halted", 64'(bus.halted), 64'(e.stat != 3'd1));
          check("cycles", 64'(cyc), 64'(e.cycles));
          check("memory_cycles", 64'(mc), 64'(e.mcyc));
          check("writeback_cycles", 64'(wc), 64'(e.wcyc));
        end
        act = 1'b0;
      end
      check("onehot", 64'($countones({bus.fetch_en, bus.decode_en, bus.execute_en,
                                      bus.memory_en, bus.writeback_en}) <= 1), 64'd1);
      if (bus.fetch_en) begin
        act = 1'b1; cyc = 1; mc = 0; wc = 0;
      end else if (act) begin
        cyc++;
        if (bus.memory_en)    mc++;
        if (bus.writeback_en) wc++;
      end
      pr = bus.retire;
      ph = bus.halted;
    end
  end

  initial begin
    #200000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t in;
    int     r;
    reset = 1'b1;
    bus.start = 1'b0; bus.icode = '0; bus.instruct_error = 1'b0; bus.imem_error = 1'b0;
    bus.dmem_error = 1'b0; bus.mem_ready = 1'b0; bus.cnd = 1'b0;
    bus.valC = '0; bus.valP = '0; bus.valM = '0;
    model_pc = RESET_PC;
    do_reset();

    repeat (5) begin
      @(posedge clk); #1;
      check("idle_pc", bus.pc, RESET_PC);
      check("idle_stat", 64'(bus.stat), 64'd1);
      check("idle_outputs", 64'({bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en,
                                 bus.writeback_en, bus.halted, bus.retire}), 64'd0);
    end

    start_run();
    check("fetch_after_start", 64'(bus.fetch_en), 64'd1);
    run_instr(mk(4'h1, 1'b0, 64'h0, 64'h1, 64'h0, NEVER, NEVER));
    run_instr(mk(4'h7, 1'b1, 64'h40, 64'h9, 64'h0, NEVER, NEVER));
    run_instr(mk(4'h7, 1'b0, 64'h40, 64'h9, 64'h0, NEVER, NEVER));
    run_instr(mk(4'h9, 1'b0, 64'h0, 64'h0, 64'h100, 3, NEVER));
    run_instr(mk(4'h9, 1'b0, 64'h0, 64'h0, 64'h200, 15, NEVER));
    run_instr(mk(4'h8, 1'b0, 64'h300, 64'h0, 64'h0, 0, NEVER));
    run_instr(mk(4'h5, 1'b0, 64'h0, 64'h310, 64'h0, 2, 2));
    check("dmem_fault_halted", 64'(bus.halted), 64'd1);

    do_reset(); start_run();
    run_instr(mk(4'h9, 1'b0, 64'h0, 64'h0, 64'h100, NEVER, NEVER));
    check("timeout_stat", 64'(bus.stat), 64'd3);

    do_reset(); start_run();
    run_instr(mk(4'h0, 1'b0, 64'h0, 64'h21, 64'h0, NEVER, NEVER));
    repeat (3) begin
      bus.start = 1'b1; @(posedge clk); #1;
      bus.start = 1'b0; @(posedge clk); #1;
      check("halt_sticky", 64'({bus.halted, bus.fetch_en, bus.decode_en, bus.execute_en,
                                bus.memory_en, bus.writeback_en}), 64'b100000);
      check("halt_pc", bus.pc, 64'h21);
      check("halt_stat", 64'(bus.stat), 64'd2);
    end

    do_reset(); start_run();
    run_instr(mk(4'h1, 1'b0, 64'h0, 64'h30, 64'h0, NEVER, NEVER));
    in = mk(4'h6, 1'b0, 64'h0, 64'h32, 64'h0, NEVER, NEVER);
    in.ins_err = 1'b1;
    run_instr(in);

    do_reset(); start_run();
    in = mk(4'h1, 1'b0, 64'h0, 64'h2, 64'h0, NEVER, NEVER);
    in.ins_err = 1'b1; in.imem_err = 1'b1;
    run_instr(in);

    do_reset(); start_run();
    run_instr(mk(4'h1, 1'b0, 64'h0, 64'h55, 64'h0, NEVER, NEVER));
    bus.icode = 4'h1; bus.valP = 64'h77;
    r = 0;
    while (!bus.execute_en && r < 10) begin @(posedge clk); #1; r++; end
    check("reached_execute", 64'(bus.execute_en), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", 64'({bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en,
                                   bus.writeback_en, bus.halted, bus.retire}), 64'd0);
    check("midreset_pc", bus.pc, RESET_PC);
    check("midreset_stat", 64'(bus.stat), 64'd1);
    reset = 1'b0;
    model_pc = RESET_PC;
    @(posedge clk); #1;
    check("idle_holds", 64'(bus.fetch_en), 64'd0);

`ifdef SEQ_PERF_COUNTERS_EN
    do_reset(); start_run();
    run_instr(mk(4'h1, 1'b0, 64'h0, 64'h1, 64'h0, NEVER, NEVER));
    run_instr(mk(4'h1, 1'b0, 64'h0, 64'h2, 64'h0, NEVER, NEVER));
    check("instr_count", bus.instr_count, 64'd2);
    check("cycle_count", bus.cycle_count, 64'd12);
`endif

    do_reset(); start_run();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      in.icode    = (r < 4) ? 4'h0 : 4'($urandom_range(1, 11));
      in.cnd      = 1'($urandom_range(0, 1));
      in.valc     = {$urandom, $urandom};
      in.valp     = {$urandom, $urandom};
      in.valm     = {$urandom, $urandom};
      in.imem_err = ($urandom_range(0, 29) == 0);
      in.ins_err  = ($urandom_range(0, 29) == 0);
      if (in.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        r = $urandom_range(0, 9);
        in.ready_at = (r == 0) ? NEVER : (r == 1) ? 15 : $urandom_range(0, 6);
        in.dmem_at  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 4) : NEVER;
      end else begin
        in.ready_at = $urandom_range(0, 3);
        in.dmem_at  = NEVER;
      end
      run_instr(in);
      if (bus.halted) begin do_reset(); start_run(); end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
